// File: rtl/job_dispatcher_pkg.sv
// Shared types and constants for the job dispatcher slice.
// Holds the FSM state encoding and the job field widths.
package dispatch_pkg;

  localparam int X_W         = 8;
  localparam int ON_W        = 2;
  localparam int JOB_W       = X_W + ON_W;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACT  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/job_dispatcher_fifo.sv
// job_fifo: DEPTH x W job buffer with wrapping pointers and an occupancy count.
// The caller guarantees that push only happens below full and pop only happens when non-empty.
module job_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/job_dispatcher.sv
// job_dispatcher: queues jobs and hands them one at a time to the main unit via a start/active handshake.
// Define JOB_TIMEOUT_EN to add a wait-state timeout that aborts the job and raises a sticky err.
module job_dispatcher
  import dispatch_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [X_W-1:0]         in_x,
  input  logic [ON_W-1:0]        in_on,
  output logic [X_W-1:0]         x,
  output logic [ON_W-1:0]        on,
  output logic                   start,
  input  logic                   active,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             done_cnt,
  output logic                   err
);

  localparam int LW = $clog2(DEPTH) + 1;

  state_t           state;
  state_t           next_state;
  logic             push;
  logic             pop;
  logic             done_inc;
  logic             tmo;
  logic [JOB_W-1:0] head;

  assign in_ready = (level < LW'(DEPTH));
  assign push     = in_valid & in_ready;

  job_fifo #(
    .DEPTH (DEPTH),
    .W     (JOB_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({in_x, in_on}),
    .rdata (head),
    .level (level)
  );

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    done_inc   = 1'b0;
    case (state)
      IDLE: begin
        if ((level != '0) && !active) begin
          next_state = ISSUE;
          pop        = 1'b1;
        end
      end
      ISSUE:    next_state = WAIT_ACT;
      WAIT_ACT: begin
        if (active)   next_state = WAIT_DONE;
        else if (tmo) next_state = IDLE;
      end
      WAIT_DONE: begin
        if (!active) begin
          next_state = IDLE;
          done_inc   = 1'b1;
        end else if (tmo) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign start = (state == ISSUE);
  assign busy  = (state != IDLE);

  // x/on keep the last popped job until the next pop, even while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      x        <= '0;
      on       <= '0;
      done_cnt <= '0;
    end else begin
      state <= next_state;
      if (pop)      {x, on}  <= head;
      if (done_inc) done_cnt <= done_cnt + 8'd1;
    end
  end

`ifdef JOB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wait_cnt;

  assign tmo = (wait_cnt == TW'(TIMEOUT - 1));

  // Counter restarts on every state change, so each wait state gets its own TIMEOUT budget.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (next_state != state) wait_cnt <= '0;
      else                     wait_cnt <= wait_cnt + TW'(1);
      if (tmo && (((state == WAIT_ACT) && !active) || ((state == WAIT_DONE) && active)))
        err <= 1'b1;
    end
  end
`else
  // No timeout in this build: tmo is constant false and the wait states block indefinitely.
  assign tmo = (TIMEOUT < 0);
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_job_dispatcher.sv
// Self-checking bench for job_dispatcher against a job-lifecycle reference model with a queue.
// Honours JOB_TIMEOUT_EN so the same bench covers both builds.
module tb_job_dispatcher;
  import dispatch_pkg::*;

  localparam int DEPTH      = 4;
  localparam int TB_TIMEOUT = 8;
  localparam int LW         = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [7:0] jx;
    logic [1:0] jon;
  } job_t;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_x     = '0;
  logic [1:0]    in_on    = '0;
  logic [7:0]    x;
  logic [1:0]    on;
  logic          start;
  logic          active   = 1'b0;
  logic          busy;
  logic [LW-1:0] level;
  logic [7:0]    done_cnt;
  logic          err;

  job_dispatcher #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .in_on    (in_on),
    .x        (x),
    .on       (on),
    .start    (start),
    .active   (active),
    .busy     (busy),
    .level    (level),
    .done_cnt (done_cnt),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model: queued jobs plus the lifecycle of the job currently handed to main.
  job_t       q[$];
  bit         m_inflight;
  bit         m_started;
  bit         m_act_seen;
  bit         m_err;
  bit         m_pushed;
  int         m_wait;
  int         m_done_total;
  logic [7:0] m_x;
  logic [1:0] m_on;

  int   pushed;
  int   cyc;
  bit   pend_v;
  job_t pend;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [7:0] jx, input logic [1:0] jon, input bit act);
    in_valid = v;
    in_x     = jx;
    in_on    = jon;
    active   = act;
  endtask

  task automatic model_reset();
    q.delete();
    m_inflight   = 0;
    m_started    = 0;
    m_act_seen   = 0;
    m_err        = 0;
    m_pushed     = 0;
    m_wait       = 0;
    m_done_total = 0;
    m_x          = '0;
    m_on         = '0;
  endtask

  task automatic wait_tick();
    m_wait++;
`ifdef JOB_TIMEOUT_EN
    if (m_wait >= TB_TIMEOUT) begin
      m_inflight = 0;
      m_err      = 1;
    end
`endif
  endtask

  task automatic model_update();
    bit do_pop;
    bit do_push;
    do_pop   = !m_inflight && (q.size() > 0) && !active;
    do_push  = in_valid && (q.size() < DEPTH);
    m_pushed = do_push;
    if (m_inflight) begin
      if (!m_started) begin
        m_started = 1;
        m_wait    = 0;
      end else if (!m_act_seen) begin
        if (active) begin
          m_act_seen = 1;
          m_wait     = 0;
        end else begin
          wait_tick();
        end
      end else if (!active) begin
        m_inflight = 0;
        m_done_total++;
      end else begin
        wait_tick();
      end
    end
    if (do_pop) begin
      m_x        = q[0].jx;
      m_on       = q[0].jon;
      void'(q.pop_front());
      m_inflight = 1;
      m_started  = 0;
      m_act_seen = 0;
    end
    if (do_push) q.push_back({in_x, in_on});
  endtask

  task automatic compare_all();
    checkOutput("in_ready", in_ready, q.size() < DEPTH);
    checkOutput("level", level, q.size());
    checkOutput("x", x, m_x);
    checkOutput("on", on, m_on);
    checkOutput("start", start, m_inflight && !m_started);
    checkOutput("busy", busy, m_inflight);
    checkOutput("done_cnt", done_cnt, m_done_total % 256);
    checkOutput("err", err, m_err);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic doReset();
    rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #2;
    doReset();
    checkOutput("rst_ready", in_ready, 1);
    checkOutput("rst_level", level, 0);

    // Reset while the first job is in WAIT_DONE with three more queued.
    applyStimulus(1, 8'hA1, 2'd0, 0); cycle();
    applyStimulus(1, 8'hA2, 2'd1, 0); cycle();
    applyStimulus(1, 8'hA3, 2'd2, 0); cycle();
    applyStimulus(1, 8'hA4, 2'd3, 1); cycle();
    applyStimulus(0, 8'h00, 2'd0, 1); cycle();
    checkOutput("t4_level_pre", level, 3);
    checkOutput("t4_x_pre", x, 8'hA1);
    doReset();
    checkOutput("t4_level", level, 0);
    checkOutput("t4_start", start, 0);
    checkOutput("t4_done", done_cnt, 0);
    checkOutput("t4_x", x, 0);
    applyStimulus(0, 8'h00, 2'd0, 0);

    // Single job: start two cycles after the push edge, then a full active pulse.
    applyStimulus(1, 8'h3C, 2'd1, 0); cycle();
    checkOutput("t1_start_early", start, 0);
    for (int k = 2; k <= 14; k++) begin
      applyStimulus(0, 8'h00, 2'd0, (k >= 5) && (k < 10));
      cycle();
      if (k == 2) begin
        checkOutput("t1_start", start, 1);
        checkOutput("t1_x", x, 8'h3C);
        checkOutput("t1_on", on, 1);
      end
      if (k == 3) checkOutput("t1_start_once", start, 0);
    end
    checkOutput("t1_done", done_cnt, 1);
    checkOutput("t1_busy", busy, 0);

    // Five jobs back-to-back while main is busy externally: fill, stall, then drain in order.
    doReset();
    pushed = 0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(pushed < 5, 8'(8'h50 + pushed), 2'(pushed), 1);
      cycle();
      if (m_pushed) pushed++;
      if (c == 3) begin
        checkOutput("t2_level_full", level, 4);
        checkOutput("t2_ready_full", in_ready, 0);
        checkOutput("t2_no_issue", busy, 0);
      end
    end
    for (int c = 0; c < 200; c++) begin
      applyStimulus(pushed < 5, 8'(8'h50 + pushed), 2'(pushed), 1'($urandom_range(0, 1)));
      cycle();
      if (m_pushed) pushed++;
    end
    checkOutput("t2_all_accepted", pushed, 5);

    // Main never answers: abort with err in the timeout build, wait forever otherwise.
    doReset();
    applyStimulus(1, 8'h77, 2'd2, 0); cycle();
    for (int c = 0; c < 100; c++) begin
      applyStimulus(0, 8'h00, 2'd0, 0);
      cycle();
    end
`ifdef JOB_TIMEOUT_EN
    checkOutput("t5_err", err, 1);
    checkOutput("t5_busy", busy, 0);
`else
    checkOutput("t5_err", err, 0);
    checkOutput("t5_busy", busy, 1);
`endif
    checkOutput("t5_done", done_cnt, 0);

    // Random traffic long enough to wrap the completion counter.
    doReset();
    pend_v = 0;
    cyc    = 0;
    while ((m_done_total < 260) && (cyc < 20000)) begin
      if (!pend_v && ($urandom_range(0, 9) < 9)) begin
        pend_v = 1;
        pend   = job_t'($urandom_range(0, 1023));
      end
      applyStimulus(pend_v, pend.jx, pend.jon, 1'($urandom_range(0, 1)));
      cycle();
      if (m_pushed) pend_v = 0;
      cyc++;
    end
    checkOutput("t6_budget", m_done_total >= 260, 1);
    checkOutput("t6_wrap", done_cnt, m_done_total - 256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
